save_point_ctrl: RTL and testbench

- Sequencer for the save-point sprite datapath.
- Detects a save-key press and scans the save points one per cycle through a shared squared-distance checker. It commits the first point within range, latches the respawn position, and drives the per-point "saved" display select (save_s) for a fixed number of frames.
- Sits between keyboard/kid-motion logic and the save-point renderer; the respawn outputs feed kid reset logic.

---
 rtl/save_pkg.sv | 48 ++++
 rtl/save_dist_chk.sv | 52 +++++
 rtl/save_point_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_save_point_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/save_pkg.sv
// -----------------------------------------------------------------------------
// save_pkg
// Shared types and constants for the save-point sequencer.
//   state_t      - sequencer states (ST_COOL only when SAVE_COOLDOWN_EN is set)
//   point_t      - packed screen coordinate (x, y), 10 bits each
//   SAVE_POINTS  - fixed save-point positions, index 0 in the low slot
//   KEY_SAVE     - keycode that requests a save
//   RADIUS_SQ    - squared activation radius used by the distance checker
// Optional feature macro: SAVE_COOLDOWN_EN
// -----------------------------------------------------------------------------
package save_pkg;

    localparam int N_POINTS        = 2;
    localparam int IDX_W           = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
    localparam int RADIUS          = 40;
    localparam int RADIUS_SQ       = RADIUS * RADIUS;
    localparam logic [7:0] KEY_SAVE = 8'd22;
    localparam int COOLDOWN_FRAMES = 30;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } point_t;

    // Leftmost pattern element lands in the highest index.
    localparam point_t [N_POINTS-1:0] SAVE_POINTS = '{
        '{x: 10'd625, y: 10'd290},
        '{x: 10'd270, y: 10'd440}
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT,
        ST_HOLD
`ifdef SAVE_COOLDOWN_EN
        , ST_COOL
`endif
    } state_t;

    function automatic logic [N_POINTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_POINTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/save_dist_chk.sv
// -----------------------------------------------------------------------------
// save_dist_chk
// Registered squared-distance test between the kid and one save point.
//   Clk, Reset_n  - clock, asynchronous active-low reset
//   kx, ky        - kid position latched at scan start
//   px, py        - save-point position currently being tested
//   hit           - registered: (kx-px)^2 + (ky-py)^2 <= RADIUS_SQ
// One cycle of latency; a new pair may be presented every cycle.
// -----------------------------------------------------------------------------
module save_dist_chk
    import save_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] kx,
    input  logic [9:0] ky,
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic       hit
);

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [10:0]        dx_mag;
    logic [10:0]        dy_mag;
    logic [20:0]        dx_sq;
    logic [20:0]        dy_sq;
    logic [21:0]        dist_sq;
    logic               hit_next;

    // Zero-extend before subtracting so the difference is a true signed
    // value instead of a wrapped unsigned one.
    always_comb begin
        dx       = $signed({1'b0, kx}) - $signed({1'b0, px});
        dy       = $signed({1'b0, ky}) - $signed({1'b0, py});
        dx_mag   = dx[10] ? 11'(-dx) : 11'(dx);
        dy_mag   = dy[10] ? 11'(-dy) : 11'(dy);
        dx_sq    = 21'(dx_mag) * 21'(dx_mag);
        dy_sq    = 21'(dy_mag) * 21'(dy_mag);
        dist_sq  = 22'(dx_sq) + 22'(dy_sq);
        hit_next = (dist_sq <= 22'(RADIUS_SQ));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit <= 1'b0;
        end else begin
            hit <= hit_next;
        end
    end

endmodule

// File: rtl/save_point_ctrl.sv
// -----------------------------------------------------------------------------
// save_point_ctrl
// Save-key sequencer: on a save-key edge it scans the save points one per
// cycle through a shared distance checker, commits the first point in range,
// latches the respawn position and shows the "saved" sprite for HOLD_FRAMES.
//   Clk, Reset_n   - clock, asynchronous active-low reset
//   frame_clk      - vsync; rising edge is a frame tick (synchronised here)
//   save_exist     - save points present in this room
//   kid_x, kid_y   - kid centre position
//   keycode        - current keycode
//   kid_dead       - kid is dead (level)
//   save_s         - one-hot selected saved point, 0 = none
//   respawn_x/y    - latched respawn position
//   respawn_valid  - a save has been committed since reset
//   save_pulse     - one-cycle strobe on commit
// Optional feature macro: SAVE_COOLDOWN_EN (adds a post-HOLD cooldown state).
// -----------------------------------------------------------------------------
module save_point_ctrl
    import save_pkg::*;
#(
    parameter int         HOLD_FRAMES = 60,
    parameter logic [9:0] DEFAULT_X   = 10'd40,
    parameter logic [9:0] DEFAULT_Y   = 10'd440
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_clk,
    input  logic                save_exist,
    input  logic [9:0]          kid_x,
    input  logic [9:0]          kid_y,
    input  logic [7:0]          keycode,
    input  logic                kid_dead,
    output logic [N_POINTS-1:0] save_s,
    output logic [9:0]          respawn_x,
    output logic [9:0]          respawn_y,
    output logic                respawn_valid,
    output logic                save_pulse
);

    localparam int               HOLD_W   = $clog2(HOLD_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    state_t              state_reg, state_next;

    logic [2:0]          fsync_reg;
    logic                frame_tick;
    logic                key_prev_reg;
    logic                key_is_save;
    logic                key_edge;

    logic [9:0]          kx_reg, ky_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                issue_done_reg;
    logic                res_valid_reg;
    logic [IDX_W-1:0]    res_idx_reg;
    logic                chk_hit;
    point_t              cur_pt;

    logic [N_POINTS-1:0] save_s_reg;
    logic [9:0]          respawn_x_reg, respawn_y_reg;
    logic                respawn_valid_reg;
    logic                save_pulse_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;

    logic                start_scan;
    logic                issue_valid;
    logic                do_commit;
    logic                clear_sel;
    logic                hold_dec;

`ifdef SAVE_COOLDOWN_EN
    localparam int       COOL_W = $clog2(COOLDOWN_FRAMES + 1);
    logic [COOL_W-1:0]   cool_cnt_reg;
    logic                cool_load;
    logic                cool_dec;
`endif

    // Two synchroniser flops, third flop for rising-edge detection.
    assign frame_tick  = fsync_reg[1] & ~fsync_reg[2];
    assign key_is_save = (keycode == KEY_SAVE);
    assign key_edge    = key_is_save & ~key_prev_reg;
    assign cur_pt      = SAVE_POINTS[idx_reg];

    save_dist_chk u_dist_chk (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .kx      (kx_reg),
        .ky      (ky_reg),
        .px      (cur_pt.x),
        .py      (cur_pt.y),
        .hit     (chk_hit)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        start_scan  = 1'b0;
        issue_valid = 1'b0;
        do_commit   = 1'b0;
        clear_sel   = 1'b0;
        hold_dec    = 1'b0;
`ifdef SAVE_COOLDOWN_EN
        cool_load   = 1'b0;
        cool_dec    = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (key_edge && save_exist && !kid_dead) begin
                    start_scan = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                issue_valid = ~issue_done_reg;
                if (!save_exist) begin
                    clear_sel  = 1'b1;
                    state_next = ST_IDLE;
                end else if (kid_dead) begin
                    state_next = ST_IDLE;
                end else if (res_valid_reg && chk_hit) begin
                    // Results return in index order, so the first hit seen
                    // is the lowest index in range.
                    do_commit  = 1'b1;
                    state_next = ST_COMMIT;
                end else if (res_valid_reg && (res_idx_reg == LAST_IDX)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                // Frame ticks here are deliberately not counted.
                if (!save_exist) begin
                    clear_sel  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!save_exist) begin
                    clear_sel  = 1'b1;
                    state_next = ST_IDLE;
                end else if (hold_cnt_reg == '0) begin
                    clear_sel  = 1'b1;
`ifdef SAVE_COOLDOWN_EN
                    cool_load  = 1'b1;
                    state_next = ST_COOL;
`else
                    state_next = ST_IDLE;
`endif
                end else if (frame_tick) begin
                    hold_dec = 1'b1;
                end
            end
`ifdef SAVE_COOLDOWN_EN
            ST_COOL: begin
                if (!save_exist || (cool_cnt_reg == '0)) begin
                    clear_sel  = 1'b1;
                    state_next = ST_IDLE;
                end else if (frame_tick) begin
                    cool_dec = 1'b1;
                end
            end
`endif
            default: begin
                clear_sel  = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsync_reg         <= '0;
            key_prev_reg      <= 1'b0;
            kx_reg            <= '0;
            ky_reg            <= '0;
            idx_reg           <= '0;
            issue_done_reg    <= 1'b0;
            res_valid_reg     <= 1'b0;
            res_idx_reg       <= '0;
            save_s_reg        <= '0;
            respawn_x_reg     <= DEFAULT_X;
            respawn_y_reg     <= DEFAULT_Y;
            respawn_valid_reg <= 1'b0;
            save_pulse_reg    <= 1'b0;
            hold_cnt_reg      <= '0;
        end else begin
            fsync_reg      <= {fsync_reg[1:0], frame_clk};
            key_prev_reg   <= key_is_save;
            // Tag travels alongside the checker pipeline so each registered
            // hit is matched to the index that produced it.
            res_valid_reg  <= issue_valid;
            res_idx_reg    <= idx_reg;
            save_pulse_reg <= do_commit;

            if (start_scan) begin
                kx_reg         <= kid_x;
                ky_reg         <= kid_y;
                idx_reg        <= '0;
                issue_done_reg <= 1'b0;
            end else if (issue_valid) begin
                if (idx_reg == LAST_IDX) begin
                    issue_done_reg <= 1'b1;
                end else begin
                    idx_reg <= idx_reg + IDX_W'(1);
                end
            end

            if (do_commit) begin
                respawn_x_reg     <= kx_reg;
                respawn_y_reg     <= ky_reg;
                respawn_valid_reg <= 1'b1;
                save_s_reg        <= onehot(res_idx_reg);
                hold_cnt_reg      <= HOLD_W'(HOLD_FRAMES);
            end else if (clear_sel) begin
                save_s_reg <= '0;
            end

            if (hold_dec) begin
                hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
            end
        end
    end

`ifdef SAVE_COOLDOWN_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cool_cnt_reg <= '0;
        end else if (cool_load) begin
            cool_cnt_reg <= COOL_W'(COOLDOWN_FRAMES);
        end else if (cool_dec) begin
            cool_cnt_reg <= cool_cnt_reg - COOL_W'(1);
        end
    end
`endif

    assign save_s        = save_s_reg;
    assign respawn_x     = respawn_x_reg;
    assign respawn_y     = respawn_y_reg;
    assign respawn_valid = respawn_valid_reg;
    assign save_pulse    = save_pulse_reg;

endmodule

// File: tb/tb_save_point_ctrl.sv
// -----------------------------------------------------------------------------
// tb_save_point_ctrl
// Self-checking bench for save_point_ctrl: directed boundary cases followed by
// randomized key presses. Expected results come from a geometric reference
// (distance to each save point computed with integer arithmetic) and the
// commit/hold timing rules, not from the design's internal state.
// -----------------------------------------------------------------------------
module tb_save_point_ctrl;

    localparam int KEY     = 22;
    localparam int R_SQ    = 40 * 40;
    localparam int HOLD_N  = 60;
    localparam int COOL_N  = 30;

    logic       Clk;
    logic       Reset_n;
    logic       frame_clk;
    logic       save_exist;
    logic [9:0] kid_x;
    logic [9:0] kid_y;
    logic [7:0] keycode;
    logic       kid_dead;
    logic [1:0] save_s;
    logic [9:0] respawn_x;
    logic [9:0] respawn_y;
    logic       respawn_valid;
    logic       save_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    int PX [2] = '{270, 625};
    int PY [2] = '{440, 290};

    // expected architectural outputs
    int exp_s  = 0;
    int exp_rx = 40;
    int exp_ry = 440;
    int exp_v  = 0;

    save_point_ctrl dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_clk     (frame_clk),
        .save_exist    (save_exist),
        .kid_x         (kid_x),
        .kid_y         (kid_y),
        .keycode       (keycode),
        .kid_dead      (kid_dead),
        .save_s        (save_s),
        .respawn_x     (respawn_x),
        .respawn_y     (respawn_y),
        .respawn_valid (respawn_valid),
        .save_pulse    (save_pulse)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Reset_n && save_pulse) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        step(2);
        frame_clk = 1'b0;
        step(2);
    endtask

    function automatic bit ref_hit(input int x, input int y, output int idx);
        idx = -1;
        for (int i = 0; i < 2; i++) begin
            int d;
            d = (x - PX[i]) * (x - PX[i]) + (y - PY[i]) * (y - PY[i]);
            if (d <= R_SQ) begin
                idx = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".save_s"}, int'(save_s), exp_s);
        chk({tag, ".rx"}, int'(respawn_x), exp_rx);
        chk({tag, ".ry"}, int'(respawn_y), exp_ry);
        chk({tag, ".valid"}, int'(respawn_valid), exp_v);
    endtask

    // Press the save key at (x,y) from IDLE; returns whether it committed.
    task automatic do_press(input int x, input int y, input bit dead,
                            input int hold_extra, output bit hit);
        int idx;
        int first_k;
        int p0;
        hit = ref_hit(x, y, idx) && !dead;
        kid_x    = 10'(x);
        kid_y    = 10'(y);
        kid_dead = dead;
        keycode  = 8'(KEY);
        p0       = pulse_cnt;
        first_k  = -1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            if (save_pulse && first_k < 0) first_k = k;
        end
        step(hold_extra);
        keycode  = 8'd0;
        kid_dead = 1'b0;
        step(1);
        chk("pulse_edge", first_k, hit ? 2 + idx : -1);
        chk("pulse_count", pulse_cnt - p0, hit ? 1 : 0);
        if (hit) begin
            exp_s  = 1 << idx;
            exp_rx = x;
            exp_ry = y;
            exp_v  = 1;
        end
        check_outputs("press");
        $display("press pos=(%0d,%0d) dead=%0d held=%0d hit=%0d idx=%0d pulse_edge=%0d",
                 x, y, dead, hold_extra, hit, idx, first_k);
    endtask

    // Run the HOLD period out; a key press mid-hold must be ignored.
    task automatic expire_hold();
        int p0;
        p0 = pulse_cnt;
        for (int t = 1; t < HOLD_N; t++) begin
            tick();
            if (t == 30) begin
                keycode = 8'(KEY);
                step(3);
                keycode = 8'd0;
                step(1);
            end
        end
        chk("hold_before_last_tick", int'(save_s), exp_s);
        tick();
        step(1);
        exp_s = 0;
        chk("hold_expired", int'(save_s), 0);
        chk("hold_key_ignored", pulse_cnt - p0, 0);
`ifdef SAVE_COOLDOWN_EN
        for (int t = 1; t <= COOL_N; t++) begin
            tick();
            if (t == 10) begin
                keycode = 8'(KEY);
                step(3);
                keycode = 8'd0;
                step(1);
            end
        end
        step(2);
        chk("cool_key_ignored", pulse_cnt - p0, 0);
`endif
        $display("hold expired save_s=%0d", save_s);
    endtask

    initial begin
        bit hit;
        int x, y, p;
        int p0;

        Reset_n    = 1'b0;
        frame_clk  = 1'b0;
        save_exist = 1'b1;
        kid_x      = '0;
        kid_y      = '0;
        keycode    = '0;
        kid_dead   = 1'b0;
        step(3);
        check_outputs("in_reset");
        chk("in_reset.pulse", int'(save_pulse), 0);
        Reset_n = 1'b1;
        step(2);
        check_outputs("after_reset");
        $display("reset released");

        // point 0 in range, key held 200 cycles -> single commit
        do_press(280, 440, 1'b0, 200, hit);
        expire_hold();
        // second edge recommits
        do_press(280, 440, 1'b0, 0, hit);
        expire_hold();

        // exactly RADIUS from point 1
        do_press(625, 330, 1'b0, 0, hit);
        // save_exist drop in HOLD clears select, keeps respawn
        save_exist = 1'b0;
        step(1);
        exp_s = 0;
        check_outputs("exist_drop");
        save_exist = 1'b1;
        step(2);
        $display("save_exist dropped in hold");

        // out of range everywhere
        do_press(100, 100, 1'b0, 0, hit);

        // kid dies during the scan (would otherwise hit index 1)
        p0 = pulse_cnt;
        kid_x = 10'd625; kid_y = 10'd330; keycode = 8'(KEY);
        step(1);
        kid_dead = 1'b1;
        step(5);
        keycode = 8'd0; kid_dead = 1'b0;
        step(1);
        chk("dead_abort_pulse", pulse_cnt - p0, 0);
        check_outputs("dead_abort");
        $display("kid_dead abort in scan");

        // asynchronous reset mid-scan
        kid_x = 10'd270; kid_y = 10'd440; keycode = 8'(KEY);
        step(1);
        Reset_n = 1'b0;
        keycode = 8'd0;
        #2;
        exp_s = 0; exp_rx = 40; exp_ry = 440; exp_v = 0;
        check_outputs("reset_mid_scan");
        chk("reset_mid_scan.pulse", int'(save_pulse), 0);
        step(2);
        Reset_n = 1'b1;
        step(2);
        $display("reset mid scan");

        // randomized presses
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                p = int'($urandom_range(0, 1));
                x = PX[p] + int'($urandom_range(0, 90)) - 45;
                y = PY[p] + int'($urandom_range(0, 90)) - 45;
            end else begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
            end
            do_press(x, y, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 20)), hit);
            if (hit) expire_hold();
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
